// File: rtl/npuzzle_move_engine.sv
// Sequential ROWS x COLS sliding-puzzle move engine: serial blank scan after load, one-cycle move execution.
// Optional macro NPUZZLE_NO_BACKTRACK_EN rejects a move that exactly undoes the previous legal move.
module npuzzle_move_engine #(
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  parameter int TW    = 4,
  parameter int CNT_W = 16,
  localparam int N  = ROWS * COLS,
  localparam int PW = $clog2(N),
  localparam int BW = N * TW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [BW-1:0]    load_board,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_dir,
  output logic [BW-1:0]    board,
  output logic [PW-1:0]    blank_pos,
  output logic             rsp_valid,
  output logic             rsp_legal,
  output logic [CNT_W-1:0] move_count,
  output logic             solved,
  output logic             load_err,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_READY, S_EXEC, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    cells_q [N];
  logic [TW-1:0]    cells_d [N];
  logic [TW-1:0]    load_cells [N];
  logic [PW-1:0]    blank_pos_q, blank_pos_d;
  logic [PW-1:0]    scan_idx_q, scan_idx_d;
  logic [1:0]       dir_q, dir_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_legal_q, rsp_legal_d;
  logic [CNT_W-1:0] move_count_q, move_count_d;
  logic             load_err_q, load_err_d;
`ifdef NPUZZLE_NO_BACKTRACK_EN
  logic [1:0]       last_dir_q, last_dir_d;
  logic             last_vld_q, last_vld_d;
`endif

  // Per-cell legality is fixed at elaboration, so no runtime mod/div by COLS is needed.
  logic [N-1:0] ok_up, ok_dn, ok_lf, ok_rt, solved_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cell
      assign ok_up[gi] = (gi >= COLS);
      assign ok_dn[gi] = (gi < N - COLS);
      assign ok_lf[gi] = ((gi % COLS) != 0);
      assign ok_rt[gi] = ((gi % COLS) != COLS - 1);
      assign load_cells[gi] = load_board[BW-1-gi*TW -: TW];
      assign board[BW-1-gi*TW -: TW] = cells_q[gi];
      if (gi == N - 1) begin : g_last
        assign solved_vec[gi] = (cells_q[gi] == '0);
      end else begin : g_mid
        assign solved_vec[gi] = (cells_q[gi] == TW'(gi + 1));
      end
    end
  endgenerate

  logic          move_ok;
  logic [PW-1:0] tgt;

  always_comb begin
    move_ok = 1'b0;
    tgt     = blank_pos_q;
    case (dir_q)
      2'b00: begin move_ok = ok_up[blank_pos_q]; tgt = blank_pos_q - PW'(COLS); end
      2'b01: begin move_ok = ok_dn[blank_pos_q]; tgt = blank_pos_q + PW'(COLS); end
      2'b10: begin move_ok = ok_lf[blank_pos_q]; tgt = blank_pos_q - PW'(1);    end
      default: begin move_ok = ok_rt[blank_pos_q]; tgt = blank_pos_q + PW'(1);  end
    endcase
`ifdef NPUZZLE_NO_BACKTRACK_EN
    // Inverse direction differs only in bit 0 (up/down, left/right).
    if (last_vld_q && (dir_q == {last_dir_q[1], ~last_dir_q[0]})) move_ok = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    cells_d      = cells_q;
    blank_pos_d  = blank_pos_q;
    scan_idx_d   = scan_idx_q;
    dir_d        = dir_q;
    rsp_valid_d  = 1'b0;
    rsp_legal_d  = rsp_legal_q;
    move_count_d = move_count_q;
    load_err_d   = load_err_q;
`ifdef NPUZZLE_NO_BACKTRACK_EN
    last_dir_d   = last_dir_q;
    last_vld_d   = last_vld_q;
`endif
    case (state_q)
      S_IDLE, S_READY, S_ERR: begin
        if (load_valid) begin
          cells_d      = load_cells;
          move_count_d = '0;
          load_err_d   = 1'b0;
          scan_idx_d   = '0;
          state_d      = S_SCAN;
`ifdef NPUZZLE_NO_BACKTRACK_EN
          last_vld_d   = 1'b0;
`endif
        end else if (state_q == S_READY && cmd_valid) begin
          dir_d   = cmd_dir;
          state_d = S_EXEC;
        end
      end
      S_SCAN: begin
        if (cells_q[scan_idx_q] == '0) begin
          blank_pos_d = scan_idx_q;
          state_d     = S_READY;
        end else if (scan_idx_q == PW'(N - 1)) begin
          load_err_d = 1'b1;
          state_d    = S_ERR;
        end else begin
          scan_idx_d = scan_idx_q + PW'(1);
        end
      end
      S_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_legal_d = move_ok;
        state_d     = S_READY;
        if (move_ok) begin
          cells_d[blank_pos_q] = cells_q[tgt];
          cells_d[tgt]         = '0;
          blank_pos_d          = tgt;
          if (move_count_q != '1) move_count_d = move_count_q + CNT_W'(1);
`ifdef NPUZZLE_NO_BACKTRACK_EN
          last_dir_d = dir_q;
          last_vld_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cells_q      <= '{default: '0};
      blank_pos_q  <= '0;
      scan_idx_q   <= '0;
      dir_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_legal_q  <= 1'b0;
      move_count_q <= '0;
      load_err_q   <= 1'b0;
`ifdef NPUZZLE_NO_BACKTRACK_EN
      last_dir_q   <= '0;
      last_vld_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cells_q      <= cells_d;
      blank_pos_q  <= blank_pos_d;
      scan_idx_q   <= scan_idx_d;
      dir_q        <= dir_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_legal_q  <= rsp_legal_d;
      move_count_q <= move_count_d;
      load_err_q   <= load_err_d;
`ifdef NPUZZLE_NO_BACKTRACK_EN
      last_dir_q   <= last_dir_d;
      last_vld_q   <= last_vld_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == S_READY) && !load_valid;
  assign busy       = (state_q == S_SCAN) || (state_q == S_EXEC);
  assign blank_pos  = blank_pos_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_legal  = rsp_legal_q;
  assign move_count = move_count_q;
  assign load_err   = load_err_q;
  assign solved     = &solved_vec;

endmodule

// File: tb/tb_npuzzle_move_engine.sv
// Directed bench for npuzzle_move_engine (3x3): load/scan timing, move table, error load, priority and reset corners.
module tb_npuzzle_move_engine;

  localparam int BW = 36;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [BW-1:0] load_board = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_dir = 2'b00;
  logic [BW-1:0] board;
  logic [3:0]    blank_pos;
  logic          rsp_valid;
  logic          rsp_legal;
  logic [15:0]   move_count;
  logic          solved;
  logic          load_err;
  logic          busy;

  int total = 0;
  int bad   = 0;

  npuzzle_move_engine #(.ROWS(3), .COLS(3), .TW(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_board(load_board),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .board(board), .blank_pos(blank_pos), .rsp_valid(rsp_valid),
    .rsp_legal(rsp_legal), .move_count(move_count), .solved(solved),
    .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    dir;
    logic          legal;
    logic [BW-1:0] brd;
    logic [3:0]    blank;
    logic [15:0]   cnt;
    logic          slv;
  } vec_t;

  vec_t tbl[13];
  vec_t bt[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [BW-1:0] img, input int exp_cyc, input bit with_cmd);
    int n;
    int rsp_seen;
    n = 0;
    rsp_seen = 0;
    @(negedge clk);
    load_valid = 1'b1;
    load_board = img;
    if (with_cmd) begin
      cmd_valid = 1'b1;
      cmd_dir   = 2'b01;
      #1;
      check({tag, " cmd_ready while load"}, 64'(cmd_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    cmd_valid  = 1'b0;
    check({tag, " busy after load"}, 64'(busy), 64'd1);
    check({tag, " load_err cleared"}, 64'(load_err), 64'd0);
    check({tag, " count cleared"}, 64'(move_count), 64'd0);
    if (rsp_valid) rsp_seen++;
    while (busy && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid) rsp_seen++;
    end
    check({tag, " scan cycles"}, 64'(n), 64'(exp_cyc));
    check({tag, " no rsp during load"}, 64'(rsp_seen), 64'd0);
    $display("load %s img=%09h cycles=%0d blank=%0d err=%0d", tag, img, n, blank_pos, load_err);
  endtask

  task automatic do_cmd(input string tag, input vec_t v);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = v.dir;
    #1;
    check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check({tag, " rsp early"}, 64'(rsp_valid), 64'd0);
    check({tag, " busy exec"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, " ready again"}, 64'(cmd_ready), 64'd1);
    check({tag, " legal"}, 64'(rsp_legal), 64'(v.legal));
    check({tag, " board"}, 64'(board), 64'(v.brd));
    check({tag, " blank"}, 64'(blank_pos), 64'(v.blank));
    check({tag, " count"}, 64'(move_count), 64'(v.cnt));
    check({tag, " solved"}, 64'(solved), 64'(v.slv));
    $display("cmd %s dir=%0d legal=%0d board=%09h blank=%0d count=%0d", tag, v.dir, rsp_legal, board, blank_pos, move_count);
    @(posedge clk);
    #1;
    check({tag, " rsp pulse end"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // dir, legal, board, blank, count, solved (starting from 0x123456708)
    tbl[0]  = '{2'b11, 1'b1, 36'h123456780, 4'd8, 16'd1, 1'b1};
    tbl[1]  = '{2'b01, 1'b0, 36'h123456780, 4'd8, 16'd1, 1'b1};
    tbl[2]  = '{2'b11, 1'b0, 36'h123456780, 4'd8, 16'd1, 1'b1};
    tbl[3]  = '{2'b00, 1'b1, 36'h123450786, 4'd5, 16'd2, 1'b0};
    tbl[4]  = '{2'b10, 1'b1, 36'h123405786, 4'd4, 16'd3, 1'b0};
    tbl[5]  = '{2'b00, 1'b1, 36'h103425786, 4'd1, 16'd4, 1'b0};
    tbl[6]  = '{2'b00, 1'b0, 36'h103425786, 4'd1, 16'd4, 1'b0};
    tbl[7]  = '{2'b10, 1'b1, 36'h013425786, 4'd0, 16'd5, 1'b0};
    tbl[8]  = '{2'b10, 1'b0, 36'h013425786, 4'd0, 16'd5, 1'b0};
    tbl[9]  = '{2'b01, 1'b1, 36'h413025786, 4'd3, 16'd6, 1'b0};
    tbl[10] = '{2'b10, 1'b0, 36'h413025786, 4'd3, 16'd6, 1'b0};
    tbl[11] = '{2'b01, 1'b1, 36'h413725086, 4'd6, 16'd7, 1'b0};
    tbl[12] = '{2'b01, 1'b0, 36'h413725086, 4'd6, 16'd7, 1'b0};

    // From 0x123456780: left, right, up
    bt[0] = '{2'b10, 1'b1, 36'h123456708, 4'd7, 16'd1, 1'b0};
`ifdef NPUZZLE_NO_BACKTRACK_EN
    bt[1] = '{2'b11, 1'b0, 36'h123456708, 4'd7, 16'd1, 1'b0};
    bt[2] = '{2'b00, 1'b1, 36'h123406758, 4'd4, 16'd2, 1'b0};
`else
    bt[1] = '{2'b11, 1'b1, 36'h123456780, 4'd8, 16'd2, 1'b1};
    bt[2] = '{2'b00, 1'b1, 36'h123450786, 4'd5, 16'd3, 1'b0};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset board", 64'(board), 64'd0);
    check("reset blank", 64'(blank_pos), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_legal", 64'(rsp_legal), 64'd0);
    check("reset count", 64'(move_count), 64'd0);
    check("reset load_err", 64'(load_err), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset cmd_ready", 64'(cmd_ready), 64'd0);
    $display("reset released check board=%09h busy=%0d", board, busy);
    @(negedge clk);
    rst = 1'b0;

    do_load("first", 36'h123456708, 8, 1'b0);
    check("first blank", 64'(blank_pos), 64'd7);
    check("first solved", 64'(solved), 64'd0);
    check("first load_err", 64'(load_err), 64'd0);
    check("first cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 13; i++) do_cmd($sformatf("row%0d", i), tbl[i]);

    // Board without a blank ends in ERR
    do_load("nozero", 36'h123456789, 9, 1'b0);
    check("err load_err", 64'(load_err), 64'd1);
    check("err cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = 2'b01;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("err no rsp", 64'(rsp_valid), 64'd0);
      check("err not busy", 64'(busy), 64'd0);
    end
    cmd_valid = 1'b0;
    $display("cmd in ERR ignored rsp_valid=%0d", rsp_valid);

    do_load("reload", 36'h023456781, 1, 1'b0);
    check("reload blank", 64'(blank_pos), 64'd0);
    check("reload load_err", 64'(load_err), 64'd0);

    // Load and command together in READY: load wins, command dropped
    do_load("prio", 36'h123456708, 8, 1'b1);
    check("prio board", 64'(board), 64'h123456708);
    check("prio blank", 64'(blank_pos), 64'd7);
    check("prio count", 64'(move_count), 64'd0);

    // Reset asserted while a command is executing
    do_cmd("pre_rst", tbl[0]);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = 2'b00;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("rst exec busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rst exec board", 64'(board), 64'd0);
    check("rst exec blank", 64'(blank_pos), 64'd0);
    check("rst exec count", 64'(move_count), 64'd0);
    check("rst exec rsp", 64'(rsp_valid), 64'd0);
    check("rst exec busy0", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("rst exec rsp later", 64'(rsp_valid), 64'd0);
    check("rst exec legal", 64'(rsp_legal), 64'd0);
    $display("reset during exec board=%09h count=%0d rsp_valid=%0d", board, move_count, rsp_valid);
    @(negedge clk);
    rst = 1'b0;

    do_load("bt", 36'h123456780, 9, 1'b0);
    check("bt solved", 64'(solved), 64'd1);
    for (int i = 0; i < 3; i++) do_cmd($sformatf("bt%0d", i), bt[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
